// File: rtl/booth_pkg.sv
// Shared types and radix-4 Booth helpers for the MAC processing element.
package booth_pkg;

  localparam int unsigned PP_W = 64;

  typedef enum logic [2:0] {ZERO, P1, P2, M1, M2} booth_digit_t;

  typedef enum logic {S_OWN, S_FWD} drain_state_t;

  function automatic booth_digit_t booth_encode(input logic [2:0] bits);
    booth_digit_t d;
    case (bits)
      3'b001, 3'b010: d = P1;
      3'b011:         d = P2;
      3'b100:         d = M2;
      3'b101, 3'b110: d = M1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

  // The caller truncates the wide result to its accumulator width; the arithmetic is modular.
  function automatic logic signed [PP_W-1:0] booth_pp(input booth_digit_t d,
                                                      input logic signed [PP_W-1:0] q,
                                                      input int unsigned shift);
    logic signed [PP_W-1:0] m;
    case (d)
      P1:      m = q;
      P2:      m = q <<< 1;
      M1:      m = -q;
      M2:      m = -(q <<< 1);
      default: m = '0;
    endcase
    return m <<< shift;
  endfunction

endpackage

// File: rtl/booth_result_fifo.sv
// First-word-fall-through result FIFO; a push while full is taken only alongside a pop.
module booth_result_fifo
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             doPush, doPop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign doPop   = pop_i && !empty_o;
  assign doPush  = push_i && (!full_o || doPop);
  assign head_o  = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wptr_q] <= push_data_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wptr_q <= wptr_q + 1'b1;
      if (doPop)  rptr_q <= rptr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/booth_mac_pe.sv
// Systolic-row PE: pipelined radix-4 Booth multiplier, dot-product accumulator,
// result FIFO and a drain FSM that forwards the left neighbours' results.
module booth_mac_pe
  import booth_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ACC_W      = 24,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PE_INDEX   = 0,
  parameter bit          SATURATE   = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_q,
  input  logic signed [DATA_W-1:0] in_k,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_data,
  input  logic                     chain_in_valid,
  output logic                     chain_in_ready,
  input  logic signed [ACC_W-1:0]  chain_in_data
);

  localparam int unsigned NSTAGE = DATA_W / 2;
  localparam int unsigned CNT_W  = (PE_INDEX > 1) ? $clog2(PE_INDEX) : 1;
  localparam logic [CNT_W-1:0] FWD_LAST = CNT_W'((PE_INDEX > 0) ? PE_INDEX - 1 : 0);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Index 0 is the operand capture register; index i+1 holds the token after stage i.
  logic [NSTAGE:0]          vld_q, last_q, zero_q;
  logic signed [DATA_W-1:0] q_q    [NSTAGE];
  logic [DATA_W-1:0]        k_q    [NSTAGE];
  logic signed [ACC_W-1:0]  psum_q [NSTAGE];
  logic signed [ACC_W-1:0]  stageSum [NSTAGE];

  logic                    accept, inZero, stall, advance, accFire, push, pop;
  logic                    fifoFull, fifoEmpty;
  logic signed [ACC_W-1:0] fifoHead;
  logic signed [ACC_W-1:0] acc_q, acc_d, product, accSum;
  logic signed [ACC_W:0]   sumWide;
  drain_state_t            state_q, state_d;
  logic [CNT_W-1:0]        fwdCnt_q, fwdCnt_d;

  assign inZero  = (in_q == '0) || (in_k == '0);
  assign accept  = in_valid && in_ready;
  assign stall   = vld_q[NSTAGE] && last_q[NSTAGE] && fifoFull && !pop;
  assign advance = !stall;
  assign in_ready = reset_n && !stall;

  for (genvar i = 0; i < NSTAGE; i++) begin : g_stage
    logic [2:0]              digitBits;
    logic signed [ACC_W-1:0] psumIn, pp;
    if (i == 0) begin : g_first
      assign digitBits = {k_q[0][1:0], 1'b0};
      assign psumIn    = '0;
    end else begin : g_rest
      assign digitBits = k_q[i][2*i+1:2*i-1];
      assign psumIn    = psum_q[i-1];
    end
    assign pp          = ACC_W'(booth_pp(booth_encode(digitBits), PP_W'(q_q[i]), 2 * i));
    assign stageSum[i] = psumIn + pp;
  end

  // Zero tokens move only their valid/last/zero bits; operand and sum registers keep their old value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q  <= '0;
      last_q <= '0;
      zero_q <= '0;
      for (int i = 0; i < NSTAGE; i++) begin
        q_q[i]    <= '0;
        k_q[i]    <= '0;
        psum_q[i] <= '0;
      end
    end else if (advance) begin
      vld_q  <= {vld_q[NSTAGE-1:0], accept};
      last_q <= {last_q[NSTAGE-1:0], accept && in_last};
      zero_q <= {zero_q[NSTAGE-1:0], accept && inZero};
      if (accept && !inZero) begin
        q_q[0] <= in_q;
        k_q[0] <= in_k;
      end
      for (int i = 1; i < NSTAGE; i++) begin
        if (vld_q[i-1] && !zero_q[i-1]) begin
          q_q[i] <= q_q[i-1];
          k_q[i] <= k_q[i-1];
        end
      end
      for (int i = 0; i < NSTAGE; i++) begin
        if (vld_q[i] && !zero_q[i]) psum_q[i] <= stageSum[i];
      end
    end
  end

  assign product = zero_q[NSTAGE] ? '0 : psum_q[NSTAGE-1];
  assign sumWide = {acc_q[ACC_W-1], acc_q} + {product[ACC_W-1], product};
  assign accFire = advance && vld_q[NSTAGE];
  assign push    = accFire && last_q[NSTAGE];

  always_comb begin
    accSum = sumWide[ACC_W-1:0];
    if (SATURATE && (sumWide[ACC_W] != sumWide[ACC_W-1]))
      accSum = sumWide[ACC_W] ? ACC_MIN : ACC_MAX;
  end

  always_comb begin
    acc_d = acc_q;
    if (accFire) acc_d = last_q[NSTAGE] ? '0 : accSum;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) acc_q <= '0;
    else          acc_q <= acc_d;
  end

  booth_result_fifo #(
    .WIDTH (ACC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push),
    .push_data_i (accSum),
    .pop_i       (pop),
    .head_o      (fifoHead),
    .full_o      (fifoFull),
    .empty_o     (fifoEmpty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_OWN;
      fwdCnt_q <= '0;
    end else begin
      state_q  <= state_d;
      fwdCnt_q <= fwdCnt_d;
    end
  end

  // Own result first, then exactly PE_INDEX results passed through from the left.
  always_comb begin
    state_d        = state_q;
    fwdCnt_d       = fwdCnt_q;
    out_valid      = 1'b0;
    out_data       = '0;
    chain_in_ready = 1'b0;
    pop            = 1'b0;
    case (state_q)
      S_OWN: begin
        out_valid = !fifoEmpty;
        out_data  = fifoHead;
        if (!fifoEmpty && out_ready) begin
          pop = 1'b1;
          if (PE_INDEX > 0) begin
            state_d  = S_FWD;
            fwdCnt_d = '0;
          end
        end
      end
      S_FWD: begin
        out_valid      = chain_in_valid;
        out_data       = chain_in_data;
        chain_in_ready = out_ready;
        if (chain_in_valid && out_ready) begin
          if (fwdCnt_q == FWD_LAST) state_d = S_OWN;
          else                      fwdCnt_d = fwdCnt_q + 1'b1;
        end
      end
      default: state_d = S_OWN;
    endcase
    if (!reset_n) begin
      out_valid      = 1'b0;
      out_data       = '0;
      chain_in_ready = 1'b0;
      pop            = 1'b0;
    end
  end

endmodule

// File: tb/tb_booth_mac_pe.sv
// Directed bench for booth_mac_pe: a default PE, a PE_INDEX=2 chain PE and a
// saturating/wrapping 16-bit pair driven with identical operands.
module tb_booth_mac_pe;

  typedef struct {
    logic signed [7:0] q;
    logic signed [7:0] k;
    int                expected;
  } vec_t;

  localparam int NVEC = 8;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   failures = 0;
  int   edges;
  vec_t vecs [NVEC];

  logic              aValid, aLast, aOutReady, aChainValid, aInReady, aOutValid, aChainReady;
  logic signed [7:0] aQ, aK;
  logic signed [23:0] aChainData, aOutData;

  logic              cValid, cLast, cOutReady, cChainValid, cInReady, cOutValid, cChainReady;
  logic signed [7:0] cQ, cK;
  logic signed [23:0] cChainData, cOutData;

  logic              oValid, oLast, oOutReady, oChainValid;
  logic signed [7:0] oQ, oK;
  logic signed [15:0] oChainData;
  logic              sInReady, sOutValid, sChainReady, wInReady, wOutValid, wChainReady;
  logic signed [15:0] sOutData, wOutData;

  always #5 clk = ~clk;

  booth_mac_pe dutA (
    .clk(clk), .reset_n(reset_n), .in_valid(aValid), .in_ready(aInReady), .in_q(aQ), .in_k(aK),
    .in_last(aLast), .out_valid(aOutValid), .out_ready(aOutReady), .out_data(aOutData),
    .chain_in_valid(aChainValid), .chain_in_ready(aChainReady), .chain_in_data(aChainData)
  );

  booth_mac_pe #(.PE_INDEX(2)) dutC (
    .clk(clk), .reset_n(reset_n), .in_valid(cValid), .in_ready(cInReady), .in_q(cQ), .in_k(cK),
    .in_last(cLast), .out_valid(cOutValid), .out_ready(cOutReady), .out_data(cOutData),
    .chain_in_valid(cChainValid), .chain_in_ready(cChainReady), .chain_in_data(cChainData)
  );

  booth_mac_pe #(.ACC_W(16), .SATURATE(1'b1)) dutS (
    .clk(clk), .reset_n(reset_n), .in_valid(oValid), .in_ready(sInReady), .in_q(oQ), .in_k(oK),
    .in_last(oLast), .out_valid(sOutValid), .out_ready(oOutReady), .out_data(sOutData),
    .chain_in_valid(oChainValid), .chain_in_ready(sChainReady), .chain_in_data(oChainData)
  );

  booth_mac_pe #(.ACC_W(16), .SATURATE(1'b0)) dutW (
    .clk(clk), .reset_n(reset_n), .in_valid(oValid), .in_ready(wInReady), .in_q(oQ), .in_k(oK),
    .in_last(oLast), .out_valid(wOutValid), .out_ready(oOutReady), .out_data(wOutData),
    .chain_in_valid(oChainValid), .chain_in_ready(wChainReady), .chain_in_data(oChainData)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  function automatic logic readyOf(input int which);
    case (which)
      0:       return aInReady;
      1:       return cInReady;
      default: return sInReady && wInReady;
    endcase
  endfunction

  function automatic logic outValidOf(input int which);
    case (which)
      0:       return aOutValid;
      1:       return cOutValid;
      default: return sOutValid;
    endcase
  endfunction

  task automatic setOutReady(input int which, input logic v);
    case (which)
      0:       aOutReady = v;
      1:       cOutReady = v;
      default: oOutReady = v;
    endcase
  endtask

  task automatic applyStimulus(input int which, input logic signed [7:0] q,
                               input logic signed [7:0] k, input logic last);
    int guard;
    guard = 0;
    case (which)
      0:       begin aQ = q; aK = k; aLast = last; aValid = 1'b1; end
      1:       begin cQ = q; cK = k; cLast = last; cValid = 1'b1; end
      default: begin oQ = q; oK = k; oLast = last; oValid = 1'b1; end
    endcase
    while (!readyOf(which) && guard < 50) begin
      @(posedge clk); @(negedge clk);
      guard++;
    end
    checkOutput($sformatf("acceptReady%0d", which), int'(readyOf(which)), 1);
    @(posedge clk); @(negedge clk);
    aValid = 1'b0; cValid = 1'b0; oValid = 1'b0;
    aLast = 1'b0; cLast = 1'b0; oLast = 1'b0;
  endtask

  task automatic waitResult(input int which, output int n);
    n = 0;
    while (!outValidOf(which) && n < 20) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
    checkOutput($sformatf("resultArrived%0d", which), int'(outValidOf(which)), 1);
  endtask

  task automatic popOut(input int which);
    setOutReady(which, 1'b1);
    @(posedge clk); @(negedge clk);
    setOutReady(which, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); @(negedge clk); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    vecs[0] = '{q: -8'sd128, k: -8'sd128, expected: 16384};
    vecs[1] = '{q:  8'sd127, k: -8'sd128, expected: -16256};
    vecs[2] = '{q:  8'sd127, k:  8'sd127, expected: 16129};
    vecs[3] = '{q:  -8'sd1,  k:  -8'sd1,  expected: 1};
    vecs[4] = '{q: -8'sd128, k:  8'sd127, expected: -16256};
    vecs[5] = '{q:  8'sd85,  k: -8'sd86,  expected: -7310};
    vecs[6] = '{q: -8'sd37,  k:  8'sd53,  expected: -1961};
    vecs[7] = '{q:  8'sd0,   k:  8'sd5,   expected: 0};

    reset_n = 1'b0;
    aValid = 0; aLast = 0; aOutReady = 0; aChainValid = 0; aQ = 0; aK = 0; aChainData = 0;
    cValid = 0; cLast = 0; cOutReady = 0; cChainValid = 0; cQ = 0; cK = 0; cChainData = 0;
    oValid = 0; oLast = 0; oOutReady = 0; oChainValid = 0; oQ = 0; oK = 0; oChainData = 0;

    @(negedge clk);
    checkOutput("rstInReady", int'(aInReady), 0);
    checkOutput("rstOutValid", int'(aOutValid), 0);
    checkOutput("rstOutData", int'(aOutData), 0);
    checkOutput("rstChainReady", int'(cChainReady), 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkOutput("postRstInReady", int'(aInReady), 1);
    checkOutput("postRstOutValid", int'(aOutValid), 0);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(0, vecs[i].q, vecs[i].k, 1'b1);
      waitResult(0, edges);
      checkOutput($sformatf("vec%0dLatency", i), edges, 5);
      checkOutput($sformatf("vec%0dData", i), int'(aOutData), vecs[i].expected);
      popOut(0);
      checkOutput($sformatf("vec%0dPopped", i), int'(aOutValid), 0);
    end

    applyStimulus(0, 8'sd3, 8'sd7, 1'b0);
    applyStimulus(0, -8'sd5, 8'sd2, 1'b0);
    applyStimulus(0, 8'sd127, -8'sd1, 1'b1);
    waitResult(0, edges);
    checkOutput("dotLatency", edges, 5);
    checkOutput("dotData", int'(aOutData), -116);
    popOut(0);
    checkOutput("dotSingleResult", int'(aOutValid), 0);

    applyStimulus(0, 8'sd5, 8'sd0, 1'b0);
    applyStimulus(0, 8'sd0, 8'sd9, 1'b0);
    applyStimulus(0, 8'sd2, 8'sd3, 1'b1);
    waitResult(0, edges);
    checkOutput("zeroSkipLatency", edges, 5);
    checkOutput("zeroSkipData", int'(aOutData), 6);
    popOut(0);

    for (int n = 1; n <= 5; n++) applyStimulus(0, 8'(n), 8'sd1, 1'b1);
    idle(4);
    checkOutput("bpStall", int'(aInReady), 0);
    checkOutput("bpHead", int'(aOutData), 1);
    idle(2);
    checkOutput("bpStillStalled", int'(aInReady), 0);
    aOutReady = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      checkOutput($sformatf("bpValid%0d", n), int'(aOutValid), 1);
      checkOutput($sformatf("bpOrder%0d", n), int'(aOutData), n);
      @(posedge clk); @(negedge clk);
    end
    checkOutput("bpDrained", int'(aOutValid), 0);
    checkOutput("bpReadyAgain", int'(aInReady), 1);
    aOutReady = 1'b0;

    cChainValid = 1'b1;
    cChainData = 24'sd20;
    applyStimulus(1, 8'sd2, 8'sd5, 1'b1);
    applyStimulus(1, 8'sd5, 8'sd8, 1'b1);
    idle(6);
    checkOutput("chainOwnValid", int'(cOutValid), 1);
    checkOutput("chainOwnData", int'(cOutData), 10);
    cOutReady = 1'b1;
    #1;
    checkOutput("chainOwnNoPull", int'(cChainReady), 0);
    @(posedge clk); @(negedge clk);
    checkOutput("chainFwd1Data", int'(cOutData), 20);
    checkOutput("chainFwd1Ready", int'(cChainReady), 1);
    @(posedge clk); @(negedge clk);
    cChainData = 24'sd30;
    #1;
    checkOutput("chainFwd2Data", int'(cOutData), 30);
    @(posedge clk); @(negedge clk);
    cChainValid = 1'b0;
    cChainData = 24'sd0;
    #1;
    checkOutput("chainSecondOwnData", int'(cOutData), 40);
    checkOutput("chainSecondOwnValid", int'(cOutValid), 1);
    checkOutput("chainSecondOwnNoPull", int'(cChainReady), 0);
    @(posedge clk); @(negedge clk);
    checkOutput("chainFwdIdleValid", int'(cOutValid), 0);
    checkOutput("chainFwdIdleReady", int'(cChainReady), 1);
    cOutReady = 1'b0;

    repeat (2) applyStimulus(2, 8'sd127, 8'sd127, 1'b0);
    applyStimulus(2, 8'sd127, 8'sd127, 1'b1);
    waitResult(2, edges);
    checkOutput("satPos", int'(sOutData), 32767);
    checkOutput("wrapPosValid", int'(wOutValid), 1);
    checkOutput("wrapPos", int'(wOutData), -17149);
    popOut(2);

    repeat (3) applyStimulus(2, 8'sd127, 8'sd127, 1'b0);
    applyStimulus(2, -8'sd128, 8'sd127, 1'b1);
    waitResult(2, edges);
    checkOutput("satPerAdd", int'(sOutData), 16511);
    checkOutput("wrapPerAdd", int'(wOutData), 32131);
    popOut(2);

    repeat (2) applyStimulus(2, -8'sd128, 8'sd127, 1'b0);
    applyStimulus(2, -8'sd128, 8'sd127, 1'b1);
    waitResult(2, edges);
    checkOutput("satNeg", int'(sOutData), -32768);
    checkOutput("wrapNeg", int'(wOutData), 16768);
    popOut(2);

    applyStimulus(0, 8'sd3, 8'sd4, 1'b1);
    applyStimulus(0, 8'sd100, 8'sd100, 1'b0);
    applyStimulus(0, 8'sd100, 8'sd100, 1'b0);
    idle(6);
    checkOutput("preRstData", int'(aOutData), 12);
    reset_n = 1'b0;
    #1;
    checkOutput("midRstInReady", int'(aInReady), 0);
    checkOutput("midRstOutValid", int'(aOutValid), 0);
    checkOutput("midRstOutData", int'(aOutData), 0);
    checkOutput("midRstSatChain", int'(sChainReady), 0);
    checkOutput("midRstWrapChain", int'(wChainReady), 0);
    checkOutput("midRstAChain", int'(aChainReady), 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checkOutput("afterRstEmpty", int'(aOutValid), 0);
    applyStimulus(0, 8'sd2, -8'sd3, 1'b1);
    waitResult(0, edges);
    checkOutput("afterRstLatency", edges, 5);
    checkOutput("afterRstFreshAcc", int'(aOutData), -6);
    popOut(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/booth_mac_pe.md
Name: booth_mac_pe

Overview:
- Parametrised successor to the fixed 8-bit, 4-stage Booth PE.
- Radix-4 Booth multiplier of DATA_W/2 pipelined stages, feeding a K-length dot-product accumulator with optional saturation.
- Completed dot products go into a small result FIFO. A row-drain FSM emits the PE's own result, then forwards exactly PE_INDEX results from its left neighbour.
- Sits in each cell of the systolic PE array; out_* of one PE connects to chain_in_* of the PE to its right.

Parameters:
DATA_W, 8, operand width; even, >=4
ACC_W, 24, accumulator/result width; >=2*DATA_W
FIFO_DEPTH, 4, result FIFO entries; power of two, >=2
PE_INDEX, 0, number of PEs to the left in the row (results forwarded per drain)
SATURATE, 0, 1 = clamp accumulator to signed ACC_W range; 0 = two's-complement wrap

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  PE accepts operands
in_q  in  DATA_W  signed multiplicand
in_k  in  DATA_W  signed multiplier (Booth-encoded)
in_last  in  1  final element of the current dot product
out_valid  out  1  result valid toward right neighbour
out_ready  in  1  right neighbour accepts
out_data  out  ACC_W  signed result
chain_in_valid  in  1  left neighbour result valid
chain_in_ready  out  1  PE accepts left result
chain_in_data  in  ACC_W  left neighbour result

Behaviour:
- Reset: all pipeline valid bits, accumulator, FIFO pointers/count and FSM state (S_OWN) clear asynchronously.
- While reset_n is low: in_ready=0, out_valid=0, out_data=0, chain_in_ready=0.
- A reset mid-operation discards all in-flight tokens and partial sums.
- Accept: an operand pair is accepted on a clk edge with in_valid && in_ready.
- Booth pipeline: NSTAGE=DATA_W/2 stages.
  - Stage i adds digit d_i from in_k bits {2i+1, 2i, 2i-1} (bit -1 = 0), with d_i in {-2,-1,0,+1,+2}.
  - Partial product is d_i*in_q, sign-extended to ACC_W and shifted left by 2i.
  - in_k and in_last travel with the token.
- Zero-skip: if in_q==0 or in_k==0, the token still flows (valid and in_last kept) but stage adders and registers are held and the product is forced to 0. This saves power without changing timing.
- Accumulator (one cycle after stage NSTAGE-1):
  - sum = acc + product.
  - SATURATE=1: clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; saturation applies per addition.
  - SATURATE=0: wrap modulo 2^ACC_W.
  - If last: push sum into the FIFO and clear acc to 0; otherwise acc = sum.
- Latency: the result is visible at out_valid (FIFO head, state S_OWN, no backpressure) in the cycle after NSTAGE+1 edges following the accepting edge.
- Stall: when the accumulator token is last and the FIFO is full with no pop this cycle, the whole pipeline and accumulator hold.
  - in_ready = !stall (combinational).
  - Push on full is allowed when a pop occurs in the same cycle.
- FIFO: first-word-fall-through.
  - Simultaneous push and pop on empty: the pushed word appears next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- Drain FSM:
  - S_OWN:
    - out_valid = !fifo_empty, out_data = FIFO head, chain_in_ready = 0.
    - On out_valid && out_ready: pop. If PE_INDEX>0, go to S_FWD with fwd_cnt=0; else stay.
  - S_FWD:
    - out_valid = chain_in_valid, out_data = chain_in_data, chain_in_ready = out_ready.
    - On each transfer fwd_cnt++. When fwd_cnt==PE_INDEX-1 and a transfer occurs, go to S_OWN.
- out_data is held stable while out_valid && !out_ready, since sources hold.

Decomposition:
- Package booth_pkg: enum booth_digit_t {ZERO, P1, P2, M1, M2}; function booth_encode(3-bit) returning booth_digit_t; function booth_pp(digit, q, shift) returning ACC_W.
- One sub-module: booth_result_fifo (parametrised WIDTH, DEPTH; FWFT; push, pop, full, empty).

Test Plan:
1. Single element, q=-128, k=-128, last=1 -> out_data=16384, out_valid after NSTAGE+1=5 edges; also q=127, k=-128 -> -16256.
2. Three-element dot product, q=(3,-5,127), k=(7,2,-1), last on third -> single result -116; no output before the third token.
3. Zero-skip, (q=5,k=0), (q=0,k=9), (q=2,k=3,last) -> 6; stage registers hold for the zero tokens; latency unchanged.
4. Backpressure, out_ready=0, five single-element products 1..5 -> FIFO holds 4, the fifth stalls and in_ready=0. Then out_ready=1 -> results 1,2,3,4,5 in order, none lost.
5. Chain forwarding, PE_INDEX=2, own result 10, chain_in 20 then 30 -> out sequence 10,20,30; chain_in_ready=0 in S_OWN. A second own result is emitted only after 30 is transferred.
6. Overflow and reset, ACC_W=16, three products of 127*127:
   - SATURATE=1 -> 32767; SATURATE=0 -> -17149.
   - Assert reset_n low mid-accumulation -> outputs 0 immediately; the next dot product starts from acc=0.
